// File: rtl/rv32_pkg.sv
// ============================================================================
// rv32_pkg
// Shared constants and clear-sequencer state encoding for the RV32I register
// file.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// regfile_mp_if
// Read, write, issue, clear and debug signals of the multi-port register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(NREGS)
);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;

  logic                  wr0_en;
  logic [ADDR_W-1:0]     wr0_addr;
  logic [XLEN-1:0]       wr0_data;
  logic                  wr1_en;
  logic [ADDR_W-1:0]     wr1_addr;
  logic [XLEN-1:0]       wr1_data;

  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;

  logic                  clr_req;
  logic                  clr_busy;

  logic [ADDR_W-1:0]     dbg_addr;
  logic [XLEN-1:0]       dbg_data;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           iss_en, iss_addr, clr_req, dbg_addr,
    input  rd_data, rd_busy, clr_busy, dbg_data
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           iss_en, iss_addr, clr_req, dbg_addr,
    output rd_data, rd_busy, clr_busy, dbg_data
  );

endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard
// Per-register busy bits: issue sets, writeback clears, flush clears all.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  flush,
  input  wire logic                  set_en,
  input  wire logic [ADDR_W-1:0]     set_addr,
  input  wire logic                  clr0_en,
  input  wire logic [ADDR_W-1:0]     clr0_addr,
  input  wire logic                  clr1_en,
  input  wire logic [ADDR_W-1:0]     clr1_addr,
  input  wire logic [NRD*ADDR_W-1:0] rd_addr,
  output logic      [NRD-1:0]        rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // The set is applied last: a newly issued producer is younger than any
  // writeback landing in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr0_en) busy_d[clr0_addr] = 1'b0;
      if (clr1_en) busy_d[clr1_addr] = 1'b0;
      if (set_en)  busy_d[set_addr]  = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
    assign rd_busy[k] = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp
// Multi-port RV32I register file with busy scoreboard and sequenced clear.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_mp #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int NREGS  = rv32_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input wire logic   clk,
  input wire logic   rst_n,
  regfile_mp_if.slave bus
);

  import rv32_pkg::*;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];

  logic              idle;
  logic              clr_start;
  logic              wr0_eff;
  logic              wr1_eff;
  logic              iss_eff;
  logic [NRD-1:0]    sb_busy;

  // Every request input is masked while the clear sequencer owns the array.
  assign idle      = (state_q == CLR_IDLE);
  assign clr_start = idle && bus.clr_req;
  assign wr0_eff   = idle && bus.wr0_en && (bus.wr0_addr != '0);
  assign wr1_eff   = idle && bus.wr1_en && (bus.wr1_addr != '0);
  assign iss_eff   = idle && bus.iss_en && (bus.iss_addr != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (bus.clr_req) begin
          state_d = CLR_RUN;
          idx_d   = ADDR_W'(1);
        end
      end
      CLR_RUN: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NREGS - 1)) begin
          state_d = CLR_IDLE;
          idx_d   = ADDR_W'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
        idx_d   = ADDR_W'(1);
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr0_eff) regs_d[bus.wr0_addr] = bus.wr0_data;
    if (wr1_eff) regs_d[bus.wr1_addr] = bus.wr1_data;
    if (state_q == CLR_RUN) regs_d[idx_q] = '0;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      idx_q   <= ADDR_W'(1);
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.clr_busy = (state_q == CLR_RUN);

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr_start),
    .set_en    (iss_eff),
    .set_addr  (bus.iss_addr),
    .clr0_en   (wr0_eff),
    .clr0_addr (bus.wr0_addr),
    .clr1_en   (wr1_eff),
    .clr1_addr (bus.wr1_addr),
    .rd_addr   (bus.rd_addr),
    .rd_busy   (sb_busy)
  );

  // Index NRD is the debug port; it shares the read/bypass mux with the others.
  logic [ADDR_W-1:0] raddr [NRD+1];
  logic [XLEN-1:0]   rdat  [NRD+1];

  for (genvar k = 0; k < NRD; k++) begin : g_raddr
    assign raddr[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end
  assign raddr[NRD] = bus.dbg_addr;

  for (genvar k = 0; k <= NRD; k++) begin : g_rmux
`ifdef REGFILE_BYPASS_EN
    always_comb begin
      rdat[k] = regs_q[raddr[k]];
      if (wr1_eff && (bus.wr1_addr == raddr[k])) begin
        rdat[k] = bus.wr1_data;
      end else if (wr0_eff && (bus.wr0_addr == raddr[k])) begin
        rdat[k] = bus.wr0_data;
      end
    end
`else
    assign rdat[k] = regs_q[raddr[k]];
`endif
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rout
    assign bus.rd_data[k*XLEN +: XLEN] = rdat[k];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = (wr1_eff && (bus.wr1_addr == raddr[k])) ||
                 (wr0_eff && (bus.wr0_addr == raddr[k]));
    assign bus.rd_busy[k] = sb_busy[k] & ~hit;
`else
    assign bus.rd_busy[k] = sb_busy[k];
`endif
  end

  assign bus.dbg_data = rdat[NRD];

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp
// Directed self-checking bench for regfile_mp (bypass expectations follow
// REGFILE_BYPASS_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int ADDR_W = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ADDR_W(ADDR_W)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.wr0_en   = 1'b0;
    bus.wr0_addr = '0;
    bus.wr0_data = '0;
    bus.wr1_en   = 1'b0;
    bus.wr1_addr = '0;
    bus.wr1_data = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_idle();
    #1;
  endtask

  task automatic rd_set(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] d);
    bus.rd_addr  = {a1, a0};
    bus.dbg_addr = d;
    #1;
  endtask

  task automatic write0(input logic [4:0] a, input logic [31:0] v);
    bus.wr0_en   = 1'b1;
    bus.wr0_addr = a;
    bus.wr0_data = v;
    step();
  endtask

  task automatic count_clear(output int cyc);
    cyc = 0;
    while (bus.clr_busy && cyc < 64) begin
      cyc++;
      if (cyc == 10) begin
        bus.wr0_en   = 1'b1;
        bus.wr0_addr = 5'd3;
        bus.wr0_data = 32'h0000_0BAD;
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd10;
        bus.clr_req  = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    drive_idle();
    bus.rd_addr  = '0;
    bus.dbg_addr = '0;
    #1;
    check_eq("rst_clr_busy_in_reset", 32'(bus.clr_busy), 32'd0);
    check_eq("rst_rd_busy_in_reset", 32'(bus.rd_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int a = 0; a < NREGS; a++) begin
      rd_set(5'(a), 5'(a), 5'(a));
      check_eq($sformatf("rst_rd0_x%0d", a), bus.rd_data[31:0], 32'd0);
      check_eq($sformatf("rst_dbg_x%0d", a), bus.dbg_data, 32'd0);
    end
    check_eq("rst_rd_busy", 32'(bus.rd_busy), 32'd0);
    check_eq("rst_clr_busy", 32'(bus.clr_busy), 32'd0);

    // Same-address dual write: port 1 wins.
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEAD_BEEF;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd5; bus.wr1_data = 32'h1234_5678;
    step();
    rd_set(5'd5, 5'd5, 5'd5);
    check_eq("wr_prio_rd0", bus.rd_data[31:0], 32'h1234_5678);
    check_eq("wr_prio_rd1", bus.rd_data[63:32], 32'h1234_5678);
    check_eq("wr_prio_dbg", bus.dbg_data, 32'h1234_5678);
    write0(5'd0, 32'hFFFF_FFFF);
    rd_set(5'd0, 5'd0, 5'd0);
    check_eq("x0_rd0", bus.rd_data[31:0], 32'd0);
    check_eq("x0_dbg", bus.dbg_data, 32'd0);

    // Scoreboard set/clear priority on x7.
    rd_set(5'd7, 5'd7, 5'd0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    #1;
    check_eq("busy7_before_issue", 32'(bus.rd_busy), 32'd0);
    step();
    check_eq("busy7_after_issue", 32'(bus.rd_busy), 32'd3);
    step();
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h0000_0077;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    step();
    check_eq("busy7_set_beats_clear", 32'(bus.rd_busy[0]), 32'd1);
    write0(5'd7, 32'h0000_0070);
    check_eq("busy7_cleared", 32'(bus.rd_busy[1]), 32'd0);
    check_eq("x7_value", bus.rd_data[31:0], 32'h0000_0070);

    // Fill, then full clear with ignored requests mid-sequence.
    for (int i = 1; i < NREGS; i++) begin
      write0(5'(i), 32'(i));
    end
    rd_set(5'd3, 5'd31, 5'd17);
    check_eq("fill_x3", bus.rd_data[31:0], 32'd3);
    check_eq("fill_x31", bus.rd_data[63:32], 32'd31);
    check_eq("fill_x17", bus.dbg_data, 32'd17);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    step();
    rd_set(5'd9, 5'd10, 5'd0);
    check_eq("busy9_pre_clear", 32'(bus.rd_busy), 32'd1);
    bus.clr_req = 1'b1;
    step();
    check_eq("clr_busy_rises", 32'(bus.clr_busy), 32'd1);
    count_clear(cyc);
    check_eq("clear_cycles", 32'(cyc), 32'd31);
    for (int a = 0; a < NREGS; a++) begin
      rd_set(5'd9, 5'd10, 5'(a));
      check_eq($sformatf("clr_dbg_x%0d", a), bus.dbg_data, 32'd0);
    end
    check_eq("busy_after_clear", 32'(bus.rd_busy), 32'd0);
    check_eq("clr_busy_after_clear", 32'(bus.clr_busy), 32'd0);

    // Reset aborts a clear at its tenth cycle.
    write0(5'd31, 32'h0000_0031);
    write0(5'd20, 32'h0000_0020);
    bus.clr_req = 1'b1;
    step();
    repeat (9) step();
    check_eq("clr_busy_cycle10", 32'(bus.clr_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_clr_busy", 32'(bus.clr_busy), 32'd0);
    rd_set(5'd31, 5'd20, 5'd31);
    check_eq("abort_x31", bus.rd_data[31:0], 32'd0);
    check_eq("abort_x20", bus.rd_data[63:32], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_reset_idle", 32'(bus.clr_busy), 32'd0);
    write0(5'd20, 32'h0000_0020);
    bus.clr_req = 1'b1;
    step();
    count_clear(cyc);
    check_eq("clear_after_reset_cycles", 32'(cyc), 32'd31);
    rd_set(5'd20, 5'd3, 5'd20);
    check_eq("clear_after_reset_x20", bus.rd_data[31:0], 32'd0);

    // Same-cycle write-to-read forwarding.
    write0(5'd9, 32'h1111_1111);
    rd_set(5'd9, 5'd0, 5'd9);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    step();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'hA5A5_A5A5;
    #1;
    check_eq("byp_rd0", bus.rd_data[31:0], BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    check_eq("byp_dbg", bus.dbg_data, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    check_eq("byp_busy", 32'(bus.rd_busy[0]), BYP ? 32'd0 : 32'd1);
    step();
    check_eq("byp_next_rd0", bus.rd_data[31:0], 32'hA5A5_A5A5);
    check_eq("byp_next_busy", 32'(bus.rd_busy[0]), 32'd0);
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h0000_0001;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd9; bus.wr1_data = 32'h0000_0002;
    #1;
    check_eq("byp_prio_dbg", bus.dbg_data, BYP ? 32'h0000_0002 : 32'hA5A5_A5A5);
    step();
    check_eq("byp_prio_next", bus.dbg_data, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
